// File: rtl/cpu_onchip_memory_arb.sv
// Two-port round-robin arbiter in front of one shared on-chip word memory.
// Ports: clk, reset_n, clken, freeze; per port s*_chipselect/read/write/address/byteenable/writedata in, s*_waitrequest/readdata/readdatavalid out.
module cpu_onchip_memory_arb #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "cpu_onchip_memory_arb.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    freeze,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic                    s2_waitrequest,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic req1, req2, gnt1, gnt2, en, last_s2;
  logic acc_wr, acc_rd, in_range;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [IW-1:0]         mem_idx;
  logic [NB-1:0]         acc_be;
  logic [DATA_WIDTH-1:0] acc_wd, rword;

  assign en   = clken & ~freeze;
  assign req1 = s1_chipselect & (s1_read | s1_write);
  assign req2 = s2_chipselect & (s2_read | s2_write);

  // last_s2 = 1 means s2 won last, so s1 takes a tie.
  assign gnt1 = en & req1 & (~req2 | last_s2);
  assign gnt2 = en & req2 & ~gnt1;

  assign s1_waitrequest = req1 & ~gnt1;
  assign s2_waitrequest = req2 & ~gnt2;

  assign acc_addr = gnt2 ? s2_address : s1_address;
  assign acc_be   = gnt2 ? s2_byteenable : s1_byteenable;
  assign acc_wd   = gnt2 ? s2_writedata : s1_writedata;
  assign acc_wr   = (gnt1 & s1_write) | (gnt2 & s2_write);
  // read+write together is a write
  assign acc_rd   = (gnt1 & s1_read & ~s1_write)
                  | (gnt2 & s2_read & ~s2_write);

  assign in_range = {1'b0, acc_addr} < DEPTH_W;
  assign mem_idx  = acc_addr[IW-1:0];
  assign rword    = in_range ? mem[mem_idx] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_s2 <= 1'b1;
    end else if (gnt1 | gnt2) begin
      last_s2 <= gnt2;
    end
  end

  // Memory has no reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (acc_wr && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) begin
          mem[mem_idx][8*i +: 8] <= acc_wd[8*i +: 8];
        end
      end
    end
  end

  logic                  src_v, src_p;
  logic [DATA_WIDTH-1:0] src_d;

  // Latency 2 adds one stage between acceptance and the output registers.
  generate
    if (READ_LATENCY == 2) begin : g_stage
      logic                  st_v, st_p;
      logic [DATA_WIDTH-1:0] st_d;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          st_v <= 1'b0;
          st_p <= 1'b0;
          st_d <= '0;
        end else if (clken) begin
          st_v <= acc_rd;
          st_p <= gnt2;
          st_d <= rword;
        end
      end
      assign src_v = st_v;
      assign src_p = st_p;
      assign src_d = st_d;
    end else begin : g_direct
      assign src_v = acc_rd;
      assign src_p = gnt2;
      assign src_d = rword;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_readdatavalid <= 1'b0;
      s2_readdatavalid <= 1'b0;
      s1_readdata      <= '0;
      s2_readdata      <= '0;
    end else if (clken) begin
      s1_readdatavalid <= src_v & ~src_p;
      s2_readdatavalid <= src_v & src_p;
      if (src_v & ~src_p) s1_readdata <= src_d;
      if (src_v & src_p)  s2_readdata <= src_d;
    end
  end

endmodule

// File: tb/tb_cpu_onchip_memory_arb.sv
// Bench: two instances (read latency 1 and 2) driven in parallel
// and compared every cycle with a queue-based model of the arbiter.
module tb_cpu_onchip_memory_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, clken, freeze;
  logic s1_cs, s1_rd, s1_wr, s2_cs, s2_rd, s2_wr;
  logic [9:0]  s1_addr, s2_addr;
  logic [3:0]  s1_be, s2_be;
  logic [31:0] s1_wd, s2_wd;

  logic a_s1_wait, a_s2_wait, a_s1_rdv, a_s2_rdv;
  logic b_s1_wait, b_s2_wait, b_s1_rdv, b_s2_rdv;
  logic [31:0] a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata;

  cpu_onchip_memory_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000),
    .READ_LATENCY(1), .INIT_FILE("")
  ) u_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .freeze(freeze),
    .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
    .s1_address(s1_addr), .s1_byteenable(s1_be),
    .s1_writedata(s1_wd), .s1_waitrequest(a_s1_wait),
    .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_rdv),
    .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
    .s2_address(s2_addr), .s2_byteenable(s2_be),
    .s2_writedata(s2_wd), .s2_waitrequest(a_s2_wait),
    .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_rdv)
  );

  cpu_onchip_memory_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000),
    .READ_LATENCY(2), .INIT_FILE("")
  ) u_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .freeze(freeze),
    .s1_chipselect(s1_cs), .s1_read(s1_rd), .s1_write(s1_wr),
    .s1_address(s1_addr), .s1_byteenable(s1_be),
    .s1_writedata(s1_wd), .s1_waitrequest(b_s1_wait),
    .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_rdv),
    .s2_chipselect(s2_cs), .s2_read(s2_rd), .s2_write(s2_wr),
    .s2_address(s2_addr), .s2_byteenable(s2_be),
    .s2_writedata(s2_wd), .s2_waitrequest(b_s2_wait),
    .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_rdv)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } ent_t;

  logic [31:0] mmem [1024];
  bit          last_s2;
  int          en_cnt = 0;
  ent_t        q [2][$];
  logic [31:0] exp_d [2][2];
  bit          exp_v [2][2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    bit r1, r2;
    r1 = s1_cs & (s1_rd | s1_wr);
    r2 = s2_cs & (s2_rd | s2_wr);
    if (!clken || freeze) return 0;
    if (r1 && r2) return last_s2 ? 1 : 2;
    if (r1) return 1;
    if (r2) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    last_s2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      for (int p = 0; p < 2; p++) begin
        exp_v[i][p] = 1'b0;
        exp_d[i][p] = '0;
      end
    end
  endtask

  task automatic model_edge();
    int g, a;
    bit wr, rd;
    logic [3:0] be;
    logic [31:0] wd, d;
    if (!reset_n || !clken) return;
    g = model_grant();
    en_cnt++;
    if (g != 0) begin
      last_s2 = (g == 2);
      a  = (g == 1) ? int'(s1_addr) : int'(s2_addr);
      wr = (g == 1) ? s1_wr : s2_wr;
      rd = (g == 1) ? s1_rd : s2_rd;
      be = (g == 1) ? s1_be : s2_be;
      wd = (g == 1) ? s1_wd : s2_wd;
      if (wr) begin
        if (a < 1000)
          for (int k = 0; k < 4; k++)
            if (be[k]) mmem[a][8*k +: 8] = wd[8*k +: 8];
      end else if (rd) begin
        d = (a < 1000) ? mmem[a] : 32'h0;
        for (int i = 0; i < 2; i++)
          q[i].push_back('{en_cnt + i, (g == 2), d});
      end
    end
    for (int i = 0; i < 2; i++) begin
      exp_v[i][0] = 1'b0;
      exp_v[i][1] = 1'b0;
      while (q[i].size() > 0 && q[i][0].due < en_cnt)
        void'(q[i].pop_front());
      if (q[i].size() > 0 && q[i][0].due == en_cnt) begin
        exp_v[i][q[i][0].port] = 1'b1;
        exp_d[i][q[i][0].port] = q[i][0].data;
      end
    end
  endtask

  task automatic compare();
    int g;
    bit r1, r2;
    g  = model_grant();
    r1 = s1_cs & (s1_rd | s1_wr);
    r2 = s2_cs & (s2_rd | s2_wr);
    chk("a_s1_wait", a_s1_wait, r1 && g != 1);
    chk("a_s2_wait", a_s2_wait, r2 && g != 2);
    chk("b_s1_wait", b_s1_wait, r1 && g != 1);
    chk("b_s2_wait", b_s2_wait, r2 && g != 2);
    chk("a_s1_rdv", a_s1_rdv, exp_v[0][0]);
    chk("a_s2_rdv", a_s2_rdv, exp_v[0][1]);
    chk("b_s1_rdv", b_s1_rdv, exp_v[1][0]);
    chk("b_s2_rdv", b_s2_rdv, exp_v[1][1]);
    chk("a_s1_rdata", a_s1_rdata, exp_d[0][0]);
    chk("a_s2_rdata", a_s2_rdata, exp_d[0][1]);
    chk("b_s1_rdata", b_s1_rdata, exp_d[1][0]);
    chk("b_s2_rdata", b_s2_rdata, exp_d[1][1]);
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drv(input int p, input bit cs, input bit rd,
                     input bit wr, input int addr,
                     input logic [3:0] be, input logic [31:0] wd);
    if (p == 1) begin
      s1_cs = cs; s1_rd = rd; s1_wr = wr;
      s1_addr = addr[9:0]; s1_be = be; s1_wd = wd;
    end else begin
      s2_cs = cs; s2_rd = rd; s2_wr = wr;
      s2_addr = addr[9:0]; s2_be = be; s2_wd = wd;
    end
  endtask

  task automatic idle();
    drv(1, 0, 0, 0, 0, 4'h0, 32'h0);
    drv(2, 0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    model_reset();
    step();
    step();
    reset_n = 1'b1;
  endtask

  function automatic int pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 15);
    if (r < 8) return $urandom_range(995, 999);
    return $urandom_range(1000, 1023);
  endfunction

  initial begin
    reset_n = 1'b0;
    clken   = 1'b1;
    freeze  = 1'b0;
    idle();
    model_reset();
    step();
    step();
    chk("reset_rdv", a_s1_rdv, 0);
    chk("reset_rdata", b_s2_rdata, 32'h0);
    reset_n = 1'b1;

    // preload the address pool used below
    for (int a = 0; a < 16; a++) begin
      drv(1, 1, 0, 1, a, 4'hF, $urandom);
      step();
    end
    for (int a = 995; a < 1000; a++) begin
      drv(1, 1, 0, 1, a, 4'hF, $urandom);
      step();
    end

    // byte-lane write then read on the other port
    drv(1, 1, 0, 1, 5, 4'hF, 32'hAABBCCDD);
    step();
    drv(1, 1, 0, 1, 5, 4'b0101, 32'h11223344);
    step();
    idle();
    drv(2, 1, 1, 0, 5, 4'h0, 32'h0);
    step();
    chk("lane_a_rdv", a_s2_rdv, 1);
    chk("lane_a_data", a_s2_rdata, 32'hAA22CC44);
    chk("lane_b_early", b_s2_rdv, 0);
    idle();
    step();
    chk("lane_b_rdv", b_s2_rdv, 1);
    chk("lane_b_data", b_s2_rdata, 32'hAA22CC44);

    // back-to-back reads
    for (int a = 0; a < 3; a++) begin
      drv(1, 1, 1, 0, a, 4'h0, 32'h0);
      step();
    end
    idle();
    chk("b2b_b_rdv", b_s1_rdv, 1);
    step();
    chk("b2b_b_rdv_last", b_s1_rdv, 1);
    step();
    chk("b2b_b_done", b_s1_rdv, 0);

    // clken stall with a read in flight
    drv(1, 1, 1, 0, 3, 4'h0, 32'h0);
    step();
    clken = 1'b0;
    drv(2, 1, 1, 0, 4, 4'h0, 32'h0);
    #1;
    chk("stall_s1_wait", a_s1_wait, 1);
    chk("stall_s2_wait", a_s2_wait, 1);
    for (int k = 0; k < 3; k++) step();
    chk("stall_b_hold", b_s1_rdv, 0);
    chk("stall_a_hold", a_s1_rdv, 1);
    clken = 1'b1;
    idle();
    step();
    chk("stall_b_done", b_s1_rdv, 1);

    // freeze: in-flight read completes, new requests wait
    drv(1, 1, 1, 0, 4, 4'h0, 32'h0);
    step();
    freeze = 1'b1;
    drv(2, 1, 1, 0, 6, 4'h0, 32'h0);
    #1;
    chk("frz_s1_wait", b_s1_wait, 1);
    chk("frz_s2_wait", b_s2_wait, 1);
    step();
    chk("frz_b_rdv", b_s1_rdv, 1);
    freeze = 1'b0;
    idle();
    step();

    // out-of-range write/read
    drv(1, 1, 0, 1, 1010, 4'hF, 32'hFFFFFFFF);
    step();
    drv(1, 1, 1, 0, 1010, 4'h0, 32'h0);
    step();
    chk("oor_rdv", a_s1_rdv, 1);
    chk("oor_data", a_s1_rdata, 32'h0);
    drv(1, 1, 1, 0, 999, 4'h0, 32'h0);
    step();
    idle();
    step();

    // reset one cycle after acceptance, then contention
    drv(1, 1, 1, 0, 7, 4'h0, 32'h0);
    step();
    do_reset();
    chk("rst_discard", b_s1_rdv, 0);
    for (int k = 0; k < 4; k++) begin
      drv(1, 1, 1, 0, 8, 4'h0, 32'h0);
      drv(2, 1, 1, 0, 9, 4'h0, 32'h0);
      #1;
      chk("tie_s1_wait", a_s1_wait, (k % 2) == 1);
      chk("tie_s2_wait", a_s2_wait, (k % 2) == 0);
      step();
    end
    idle();
    step();
    step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        clken  = ($urandom_range(0, 9) != 0);
        freeze = ($urandom_range(0, 9) == 0);
        for (int p = 1; p <= 2; p++)
          drv(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
              $urandom_range(0, 2) == 0, pick_addr(),
              4'($urandom), $urandom);
        step();
      end
    end
    clken  = 1'b1;
    freeze = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
